sharpen_scan_ctrl: RTL and testbench

//   Window-scan sequencer for the image-sharpening extension of the DLX core. It sits

---
 rtl/sharpen_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_sharpen_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sharpen_scan_ctrl.sv
// rtl/sharpen_scan_ctrl.sv - 3x3 window-scan sequencer with req/ack pixel fetch
module sharpen_scan_ctrl #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_n,
    input  logic              pix_ack,
    output logic              pix_req,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_centre,
    output logic              busy,
    output logic              done
);
    // Window origin counters hold (centre - 1), so they start from zero
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] WX_LAST = XW'(IMG_W - 3);
    localparam logic [YW-1:0] WY_LAST = YW'(IMG_H - 3);
    localparam logic [31:0]   W32     = 32'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WIN, S_DONE} state_t;

    state_t            state, state_nx;
    logic              st_d;
    logic [XW-1:0]     wx, wx_nx;
    logic [YW-1:0]     wy, wy_nx;
    logic [1:0]        dx, dx_nx, dy, dy_nx;
    logic              pix_req_nx, win_valid_nx, busy_nx, done_nx;
    logic [ADDR_W-1:0] pix_addr_nx, win_centre_nx;
    logic              trigger;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [31:0] row, input logic [31:0] col);
        return ADDR_W'(row * W32 + col);
    endfunction

    // Falling edge of the qualified trigger; only acted upon in IDLE
    assign trigger = !start_n && st_d;

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_nx      = state;
        wx_nx         = wx;
        wy_nx         = wy;
        dx_nx         = dx;
        dy_nx         = dy;
        pix_req_nx    = 1'b0;
        pix_addr_nx   = pix_addr;
        win_valid_nx  = 1'b0;
        win_centre_nx = win_centre;
        busy_nx       = 1'b0;
        done_nx       = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nx    = S_FETCH;
                    pix_req_nx  = 1'b1;
                    busy_nx     = 1'b1;
                    pix_addr_nx = '0;
                end
            end
            S_FETCH: begin
                busy_nx    = 1'b1;
                pix_req_nx = 1'b1;
                if (pix_ack) begin
                    if (dx == 2'd2 && dy == 2'd2) begin
                        state_nx      = S_WIN;
                        pix_req_nx    = 1'b0;
                        win_valid_nx  = 1'b1;
                        win_centre_nx = addr_of(32'(wy) + 32'd1, 32'(wx) + 32'd1);
                        dx_nx         = 2'd0;
                        dy_nx         = 2'd0;
                    end else begin
                        if (dx == 2'd2) begin
                            dx_nx = 2'd0;
                            dy_nx = dy + 2'd1;
                        end else begin
                            dx_nx = dx + 2'd1;
                        end
                        pix_addr_nx = addr_of(32'(wy) + 32'(dy_nx), 32'(wx) + 32'(dx_nx));
                    end
                end
            end
            S_WIN: begin
                if (wx == WX_LAST && wy == WY_LAST) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx   = S_FETCH;
                    busy_nx    = 1'b1;
                    pix_req_nx = 1'b1;
                    if (wx == WX_LAST) begin
                        wx_nx = '0;
                        wy_nx = wy + 1'b1;
                    end else begin
                        wx_nx = wx + 1'b1;
                    end
                    pix_addr_nx = addr_of(32'(wy_nx), 32'(wx_nx));
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                wx_nx    = '0;
                wy_nx    = '0;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, counters, trigger history and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            st_d       <= 1'b1;
            wx         <= '0;
            wy         <= '0;
            dx         <= 2'd0;
            dy         <= 2'd0;
            pix_req    <= 1'b0;
            pix_addr   <= '0;
            win_valid  <= 1'b0;
            win_centre <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            st_d       <= start_n;
            wx         <= wx_nx;
            wy         <= wy_nx;
            dx         <= dx_nx;
            dy         <= dy_nx;
            pix_req    <= pix_req_nx;
            pix_addr   <= pix_addr_nx;
            win_valid  <= win_valid_nx;
            win_centre <= win_centre_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end
endmodule

// File: tb/tb_sharpen_scan_ctrl.sv
// tb/tb_sharpen_scan_ctrl.sv - self-checking bench for sharpen_scan_ctrl
module tb_sharpen_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_n = 1'b1;
    logic pix_ack = 1'b0;
    always #5 clk = ~clk;

    logic       req_w[3], wv_w[3], busy_w[3], done_w[3];
    logic [7:0] addr_w[3], cen_w[3];

    sharpen_scan_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(8)) u_4x4 (
        .clk(clk), .rst_n(rst_n), .start_n(start_n), .pix_ack(pix_ack),
        .pix_req(req_w[0]), .pix_addr(addr_w[0]), .win_valid(wv_w[0]),
        .win_centre(cen_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    sharpen_scan_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(8)) u_3x3 (
        .clk(clk), .rst_n(rst_n), .start_n(start_n), .pix_ack(pix_ack),
        .pix_req(req_w[1]), .pix_addr(addr_w[1]), .win_valid(wv_w[1]),
        .win_centre(cen_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    sharpen_scan_ctrl #(.IMG_W(16), .IMG_H(16), .ADDR_W(8)) u_16x16 (
        .clk(clk), .rst_n(rst_n), .start_n(start_n), .pix_ack(pix_ack),
        .pix_req(req_w[2]), .pix_addr(addr_w[2]), .win_valid(wv_w[2]),
        .win_centre(cen_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    int         sel = 0;
    logic       obs_req, obs_wv, obs_busy, obs_done;
    logic [7:0] obs_addr, obs_cen;
    always_comb begin
        obs_req  = req_w[sel];
        obs_wv   = wv_w[sel];
        obs_busy = busy_w[sel];
        obs_done = done_w[sel];
        obs_addr = addr_w[sel];
        obs_cen  = cen_w[sel];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start_n = 1'b1;
        pix_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {obs_req, obs_wv, obs_busy, obs_done, obs_addr, obs_cen}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference: scan every interior centre row-major, reading its 3x3 block row-major
    task automatic run_scan(input int w, input int h, input bit rand_ack, input bit pulse_busy,
                            output int req_to_done, output int nack);
        int exp_addr[$];
        int exp_cen[$];
        int ai, ci, first, done_at;
        bit got_done;
        for (int cy = 1; cy <= h - 2; cy++)
            for (int cx = 1; cx <= w - 2; cx++) begin
                exp_cen.push_back(cy * w + cx);
                for (int ddy = -1; ddy <= 1; ddy++)
                    for (int ddx = -1; ddx <= 1; ddx++)
                        exp_addr.push_back((cy + ddy) * w + cx + ddx);
            end
        ai = 0; ci = 0; first = -1; done_at = -1; got_done = 1'b0; nack = 0;
        start_n = 1'b0;
        pix_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) chk("start_latency", {obs_busy, obs_req}, 3);
            if (obs_req) begin
                if (first < 0) first = cyc;
                if (ai < exp_addr.size()) chk("pix_addr", obs_addr, exp_addr[ai]);
                else chk("extra_req", ai, exp_addr.size());
            end
            if (obs_wv) begin
                chk("reads_per_window", ai, 9 * (ci + 1));
                if (ci < exp_cen.size()) chk("win_centre", obs_cen, exp_cen[ci]);
                ci++;
            end
            chk("busy", obs_busy, obs_req | obs_wv);
            if (obs_done) begin
                got_done = 1'b1;
                done_at  = cyc;
                chk("windows_at_done", ci, exp_cen.size());
                chk("reads_at_done", ai, exp_addr.size());
            end
            if (pulse_busy && cyc == 5) start_n = 1'b1;
            if (pulse_busy && cyc == 6) start_n = 1'b0;
            pix_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            if (obs_req && pix_ack) begin
                ai++;
                nack++;
            end
        end
        chk("scan_finished", got_done, 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {obs_done, obs_busy, obs_req, obs_wv}, 0);
        req_to_done = done_at - first;
    endtask

    typedef struct packed {
        logic       s;
        logic       a;
        logic       busy;
        logic       req;
        logic [7:0] addr;
        logic       wv;
        logic [7:0] cen;
        logic       done;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic a, input logic b, input logic r,
                                input int ad, input logic w, input int c);
        vec_t v;
        v.s = s; v.a = a; v.busy = b; v.req = r;
        v.addr = 8'(ad); v.wv = w; v.cen = 8'(c); v.done = 1'b0;
        return v;
    endfunction

    initial begin
        vec_t vt[15];
        int   r2d, nk, n;
        bit   seen;

        // Stalled second read on 4x4: addr 1 is held for four samples
        vt[0]  = mk(1, 1, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 1, 0, 0, 0);
        vt[2]  = mk(0, 1, 1, 1, 1, 0, 0);
        vt[3]  = mk(0, 0, 1, 1, 1, 0, 0);
        vt[4]  = mk(0, 0, 1, 1, 1, 0, 0);
        vt[5]  = mk(0, 0, 1, 1, 1, 0, 0);
        vt[6]  = mk(0, 1, 1, 1, 2, 0, 0);
        vt[7]  = mk(0, 1, 1, 1, 4, 0, 0);
        vt[8]  = mk(0, 1, 1, 1, 5, 0, 0);
        vt[9]  = mk(0, 1, 1, 1, 6, 0, 0);
        vt[10] = mk(0, 1, 1, 1, 8, 0, 0);
        vt[11] = mk(0, 1, 1, 1, 9, 0, 0);
        vt[12] = mk(0, 1, 1, 1, 10, 0, 0);
        vt[13] = mk(0, 1, 1, 0, 0, 1, 5);
        vt[14] = mk(0, 1, 1, 1, 1, 0, 0);

        // Ack tied high on 4x4: four windows, done on the 41st cycle counting first pix_req as 1
        sel = 0;
        do_reset();
        run_scan(4, 4, 1'b0, 1'b0, r2d, nk);
        chk("t1_req_to_done", r2d, 40);
        chk("t1_acks", nk, 36);

        // start_n still held low after the run: no retrigger
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (obs_busy || obs_req) seen = 1'b1;
        end
        chk("held_low_no_retrigger", seen, 0);

        // Fresh edge, random ack, start_n pulsed while busy
        start_n = 1'b1;
        @(posedge clk);
        #1;
        run_scan(4, 4, 1'b1, 1'b1, r2d, nk);
        chk("pulse_acks", nk, 36);

        // Table-driven stall sequence
        do_reset();
        for (int i = 0; i < 15; i++) begin
            start_n = vt[i].s;
            pix_ack = vt[i].a;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ctl", i), {obs_busy, obs_req, obs_wv, obs_done},
                {vt[i].busy, vt[i].req, vt[i].wv, vt[i].done});
            if (vt[i].req) chk($sformatf("vec%0d_addr", i), obs_addr, vt[i].addr);
            if (vt[i].wv)  chk($sformatf("vec%0d_cen", i), obs_cen, vt[i].cen);
        end
        n = 13;
        pix_ack = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (obs_done) seen = 1'b1;
        end
        chk("stall_done_seen", seen, 1);
        chk("stall_req_to_done", n, 43);

        // Reset during the second window's fetch
        do_reset();
        start_n = 1'b0;
        pix_ack = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        chk("mid_win2_addr", {obs_req, obs_addr}, {1'b1, 8'd3});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {obs_req, obs_wv, obs_busy, obs_done, obs_addr, obs_cen}, 0);
        start_n = 1'b1;
        pix_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold_quiet", {obs_done, obs_wv, obs_busy}, 0);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (obs_busy || obs_done) seen = 1'b1;
        end
        chk("idle_after_reset", seen, 0);
        run_scan(4, 4, 1'b0, 1'b0, r2d, nk);
        chk("restart_req_to_done", r2d, 40);

        // Minimum image: one window
        sel = 1;
        do_reset();
        run_scan(3, 3, 1'b0, 1'b0, r2d, nk);
        chk("t3x3_req_to_done", r2d, 10);
        chk("t3x3_acks", nk, 9);

        // Full-size image under random ack
        sel = 2;
        do_reset();
        run_scan(16, 16, 1'b1, 1'b0, r2d, nk);
        chk("t16_acks", nk, 1764);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
